// File: rtl/dma_bus_arbiter_if.sv
// Bus bundle between the arbiter, the CPU core, the RAM port and the DMA master.
interface dma_bus_arbiter_if #(
  parameter int unsigned LEN_W = 8
);
  // CPU side
  logic [15:0]      cpu_address;
  logic [15:0]      cpu_data_out;
  logic             cpu_write;
  logic             cpu_busy;
  logic             cpu_hold;
  logic [15:0]      cpu_data_in;
  // RAM side
  logic [15:0]      ram_address;
  logic [15:0]      ram_data_wr;
  logic             ram_we;
  logic [15:0]      ram_data_rd;
  // DMA master side
  logic             dma_start;
  logic [15:0]      dma_base;
  logic [LEN_W-1:0] dma_len;
  logic             dma_ready;
  logic             dma_valid;
  logic [15:0]      dma_data;
  logic             dma_done;

  // Arbiter view
  modport slave (
    input  cpu_address, cpu_data_out, cpu_write, cpu_busy,
    output cpu_hold, cpu_data_in,
    output ram_address, ram_data_wr, ram_we,
    input  ram_data_rd,
    input  dma_start, dma_base, dma_len,
    output dma_ready, dma_valid, dma_data, dma_done
  );

  // Environment view (CPU, RAM and DMA master together)
  modport master (
    output cpu_address, cpu_data_out, cpu_write, cpu_busy,
    input  cpu_hold, cpu_data_in,
    input  ram_address, ram_data_wr, ram_we,
    output ram_data_rd,
    output dma_start, dma_base, dma_len,
    input  dma_ready, dma_valid, dma_data, dma_done
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Shares one synchronous RAM port between the CPU and a burst-read DMA master.
// The CPU is parked via hold/busy, a contiguous burst is streamed out, and a
// CPU-only cooldown follows every burst so the CPU cannot be starved.
module dma_bus_arbiter #(
  parameter int unsigned LEN_W          = 8,
  parameter int unsigned MIN_CPU_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  dma_bus_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MIN_CPU_CYCLES > 1) ? $clog2(MIN_CPU_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_WAIT,
    BURST,
    DRAIN,
    COOLDOWN
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             grant;      // 1 = DMA owns the RAM port
  logic             settled;    // HOLD_WAIT has lasted one full cycle
  logic [15:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [CNT_W-1:0] cool_cnt;
  logic             valid_q;
  logic             done_q;
  logic             last_word;

  assign last_word = (issued == len_q - LEN_W'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decision
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.dma_start) begin
          if (bus.dma_len == '0) state_next = COOLDOWN;
          else                   state_next = HOLD_WAIT;
        end
      end
      HOLD_WAIT: begin
        if (settled && bus.cpu_busy) state_next = BURST;
      end
      BURST: begin
        if (last_word) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = COOLDOWN;
      end
      COOLDOWN: begin
        if (cool_cnt == CNT_W'(MIN_CPU_CYCLES - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst datapath, grant flag, cooldown counter and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= 1'b0;
      settled  <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      cool_cnt <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.dma_start) begin
        base_q <= bus.dma_base;
        len_q  <= bus.dma_len;
        issued <= '0;
      end else if (state == BURST && !last_word) begin
        issued <= issued + LEN_W'(1);
      end
      // grant tracks the upcoming state so it is a true register, not a decode
      grant    <= (state_next == BURST) || (state_next == DRAIN);
      settled  <= (state == HOLD_WAIT);
      cool_cnt <= (state == COOLDOWN) ? cool_cnt + CNT_W'(1) : '0;
      valid_q  <= (state == BURST) && grant;
      done_q   <= (state_next == COOLDOWN) && (state != COOLDOWN);
    end
  end

  // Output decode and RAM port mux
  always_comb begin
    bus.cpu_hold    = (state == HOLD_WAIT) || (state == BURST) || (state == DRAIN);
    bus.dma_ready   = (state == IDLE);
    bus.dma_valid   = valid_q;
    bus.dma_done    = done_q;
    bus.dma_data    = bus.ram_data_rd;
    bus.cpu_data_in = bus.ram_data_rd;
    if (grant) begin
      bus.ram_address = base_q + 16'(issued);
      bus.ram_data_wr = '0;
      bus.ram_we      = 1'b0;
    end else begin
      bus.ram_address = bus.cpu_address;
      bus.ram_data_wr = bus.cpu_data_out;
      bus.ram_we      = bus.cpu_write;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter with a parked-CPU model and a
// registered-read RAM model.
module tb_dma_bus_arbiter;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned MIN_CPU = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_bus_arbiter_if #(.LEN_W(LEN_W)) bus();

  dma_bus_arbiter #(.LEN_W(LEN_W), .MIN_CPU_CYCLES(MIN_CPU)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM: synchronous write, registered read
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_address] <= bus.ram_data_wr;
    bus.ram_data_rd <= mem[bus.ram_address];
  end

  // CPU parked in select: raises busy one edge after it sees hold
  always @(posedge clk or posedge reset) begin
    if (reset) bus.cpu_busy <= 1'b0;
    else       bus.cpu_busy <= bus.cpu_hold;
  end

  // Scoreboard queues
  logic [15:0] exp_addr [$];
  logic [15:0] exp_data [$];
  int          exp_done [$];   // expected valid count per burst

  task automatic exp_word(input logic [15:0] a, input logic [15:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // Monitor: pops and compares whenever the DUT presents a word or a done
  int          cyc = 0;
  int          vcount = 0;
  int          done_cyc = 0;
  bit          wait_ready = 0;
  logic [15:0] prev_addr = '0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      vcount     = 0;
      wait_ready = 0;
    end else begin
      if (bus.dma_valid) begin
        vcount++;
        if (exp_data.size() == 0) begin
          check("no_extra_valid", 32'(bus.dma_valid), 32'd0);
        end else begin
          check("dma_data", 32'(bus.dma_data), 32'(exp_data.pop_front()));
          check("burst_addr", 32'(prev_addr), 32'(exp_addr.pop_front()));
          check("burst_we_low", 32'(prev_we), 32'd0);
        end
      end
      if (bus.dma_done) begin
        if (exp_done.size() == 0) begin
          check("no_extra_done", 32'(bus.dma_done), 32'd0);
        end else begin
          check("valid_count", 32'(vcount), 32'(exp_done.pop_front()));
        end
        vcount     = 0;
        wait_ready = 1;
        done_cyc   = cyc;
      end else if (wait_ready && bus.dma_ready) begin
        check("ready_after_done", 32'(cyc - done_cyc), 32'(MIN_CPU));
        wait_ready = 0;
      end
    end
    prev_addr = bus.ram_address;
    prev_we   = bus.ram_we;
  end

  // Stimulus slot: just after the monitor's sample point
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.dma_done && n < 60) begin
      next_cycle();
      n++;
    end
    check({name, "_done_seen"}, 32'(bus.dma_done), 32'd1);
  endtask

  task automatic start_burst(input logic [15:0] base, input logic [LEN_W-1:0] len);
    bus.dma_start = 1'b1;
    bus.dma_base  = base;
    bus.dma_len   = len;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0100] = 16'h00A0; mem[16'h0101] = 16'h00A1;
    mem[16'h0102] = 16'h00A2; mem[16'h0103] = 16'h00A3;
    mem[16'hFFFE] = 16'hE0FE; mem[16'hFFFF] = 16'hE0FF;
    mem[16'h0000] = 16'hE000; mem[16'h0001] = 16'hE001;
    mem[16'h0300] = 16'h3300; mem[16'h0301] = 16'h3301;
    mem[16'h0200] = 16'h2200; mem[16'h0201] = 16'h2201; mem[16'h0202] = 16'h2202;
    mem[16'h0400] = 16'h4400;
    mem[16'h0050] = 16'h5A5A;

    reset            = 1'b1;
    bus.cpu_address  = 16'h1234;
    bus.cpu_data_out = 16'h5678;
    bus.cpu_write    = 1'b1;
    bus.dma_start    = 1'b0;
    bus.dma_base     = '0;
    bus.dma_len      = '0;
    #1;
    check("rst_hold", 32'(bus.cpu_hold), 32'd0);
    check("rst_ready", 32'(bus.dma_ready), 32'd1);
    check("rst_valid", 32'(bus.dma_valid), 32'd0);
    check("rst_done", 32'(bus.dma_done), 32'd0);
    check("rst_mux_addr", 32'(bus.ram_address), 32'h1234);
    check("rst_mux_wdata", 32'(bus.ram_data_wr), 32'h5678);
    check("rst_mux_we", 32'(bus.ram_we), 32'd1);
    bus.cpu_write   = 1'b0;
    bus.cpu_address = 16'h0050;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Basic burst: base 0x0100, len 4
    exp_word(16'h0100, 16'h00A0); exp_word(16'h0101, 16'h00A1);
    exp_word(16'h0102, 16'h00A2); exp_word(16'h0103, 16'h00A3);
    exp_done.push_back(4);
    start_burst(16'h0100, 8'd4);
    next_cycle();
    check("hold_at_accept", 32'(bus.cpu_hold), 32'd1);
    check("ready_falls", 32'(bus.dma_ready), 32'd0);
    bus.dma_start = 1'b0;
    n = 1;
    while (!bus.dma_valid && n < 20) begin
      next_cycle();
      n++;
    end
    check("start_to_first_valid", 32'(n), 32'd4);
    wait_done("basic");
    check("hold_low_at_done", 32'(bus.cpu_hold), 32'd0);
    repeat (MIN_CPU + 1) next_cycle();

    // CPU store in flight when the request arrives
    exp_word(16'h0300, 16'h3300); exp_word(16'h0301, 16'h3301);
    exp_done.push_back(2);
    bus.cpu_address  = 16'h0020;
    bus.cpu_data_out = 16'hBEEF;
    bus.cpu_write    = 1'b1;
    start_burst(16'h0300, 8'd2);
    next_cycle();
    bus.dma_start = 1'b0;
    check("store_we_1", 32'(bus.ram_we), 32'd1);
    check("store_addr_1", 32'(bus.ram_address), 32'h0020);
    next_cycle();
    check("store_we_2", 32'(bus.ram_we), 32'd1);
    check("store_addr_2", 32'(bus.ram_address), 32'h0020);
    bus.cpu_write   = 1'b0;
    bus.cpu_address = 16'h0050;
    wait_done("store");
    check("store_in_ram", 32'(mem[16'h0020]), 32'hBEEF);
    repeat (MIN_CPU + 1) next_cycle();

    // Address wrap
    exp_word(16'hFFFE, 16'hE0FE); exp_word(16'hFFFF, 16'hE0FF);
    exp_word(16'h0000, 16'hE000); exp_word(16'h0001, 16'hE001);
    exp_done.push_back(4);
    start_burst(16'hFFFE, 8'd4);
    next_cycle();
    bus.dma_start = 1'b0;
    wait_done("wrap");
    repeat (MIN_CPU + 1) next_cycle();

    // Zero-length request
    exp_done.push_back(0);
    start_burst(16'h0700, 8'd0);
    next_cycle();
    bus.dma_start = 1'b0;
    check("len0_done_next", 32'(bus.dma_done), 32'd1);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.cpu_hold || bus.dma_valid) saw = 1'b1;
      next_cycle();
    end
    check("len0_no_hold_valid", 32'(saw), 32'd0);
    check("len0_ready_again", 32'(bus.dma_ready), 32'd1);

    // Request held high: cooldown must separate back-to-back bursts
    exp_word(16'h0200, 16'h2200); exp_word(16'h0201, 16'h2201); exp_word(16'h0202, 16'h2202);
    exp_word(16'h0200, 16'h2200); exp_word(16'h0201, 16'h2201); exp_word(16'h0202, 16'h2202);
    exp_done.push_back(3);
    exp_done.push_back(3);
    bus.cpu_address = 16'h0050;
    start_burst(16'h0200, 8'd3);
    next_cycle();
    wait_done("cont1");
    n = 0;
    while (bus.ram_address == bus.cpu_address && n < 50) begin
      n++;
      if (n == 2) check("cooldown_fetch", 32'(bus.cpu_data_in), 32'h5A5A);
      next_cycle();
    end
    check("cpu_cycles_between", 32'(n), 32'd7);
    bus.dma_start = 1'b0;
    wait_done("cont2");
    repeat (MIN_CPU + 1) next_cycle();

    // Reset during the second word of a 10-word burst
    exp_word(16'h0400, 16'h4400);
    start_burst(16'h0400, 8'd10);
    next_cycle();
    bus.dma_start = 1'b0;
    n = 0;
    while (!bus.dma_valid && n < 20) begin
      next_cycle();
      n++;
    end
    check("rb_first_valid", 32'(bus.dma_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("rb_hold", 32'(bus.cpu_hold), 32'd0);
    check("rb_valid", 32'(bus.dma_valid), 32'd0);
    check("rb_ready", 32'(bus.dma_ready), 32'd1);
    check("rb_done", 32'(bus.dma_done), 32'd0);
    check("rb_grant_cpu", 32'(bus.ram_address), 32'h0050);
    check("rb_one_word_seen", 32'(exp_data.size()), 32'd0);
    next_cycle();
    reset = 1'b0;
    repeat (20) next_cycle();

    check("queue_empty", 32'(exp_data.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
